// File: rtl/sdhc_pkg.sv
// Shared definitions for the SD host command-response path.
// Holds the response receiver state encoding, frame lengths and the CRC7
// polynomial plus a single-step CRC7 helper used by sdhc_crc7.
package sdhc_pkg;

    // Response receiver states
    typedef enum logic [1:0] {
        RSP_IDLE       = 2'd0,
        RSP_WAIT_START = 2'd1,
        RSP_RECV       = 2'd2,
        RSP_DONE       = 2'd3
    } rsp_state_t;

    // Frame lengths including start and end bits
    localparam int RSP_SHORT_BITS = 48;
    localparam int RSP_LONG_BITS  = 136;

    // x^7 + x^3 + 1, implicit x^7 term
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // One serial CRC7 step, data fed MSB first
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sdhc_crc7.sv
// Serial CRC7 generator/checker shared by the command transmitter and the
// response receiver. clr has priority over en; register starts at zero.
module sdhc_crc7
    import sdhc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;

    // CRC shift register: clear on request, otherwise absorb one bit per enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 7'h00;
        end else if (clr) begin
            crc_q <= 7'h00;
        end else if (en) begin
            crc_q <= crc7_step(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/sdhc_rsp_rx.sv
// SD command-line response receiver.
// Armed by the command transmitter, it hunts for the start bit, shifts in a
// 48-bit (R1/R3/R6/R7) or 136-bit (R2) response on sd_clk_rise strobes,
// checks CRC7 and framing, and emits a one-cycle rsp_valid pulse.
// Optional feature: define SDHC_RSP_TIMEOUT_EN to build the NCR timeout
// counter (TIMEOUT_CLKS strobes); otherwise WAIT_START waits until abort and
// rsp_timeout is tied low.
module sdhc_rsp_rx
    import sdhc_pkg::*;
#(
    parameter int DATAW        = 32,
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sd_clk_rise,
    input  logic         sd_cmd_in,
    input  logic         arm,
    input  logic         long_rsp,
    input  logic         crc_skip,
    input  logic         abort,
    output logic         busy,
    output logic         rsp_valid,
    output logic [5:0]   rsp_index,
    output logic [127:0] rsp_data,
    output logic         rsp_crc_err,
    output logic         rsp_frame_err,
    output logic         rsp_timeout
);

    // Short responses keep only the argument field in the low DATAW bits
    localparam logic [127:0] ARG_MASK = (128'd1 << DATAW) - 128'd1;

    rsp_state_t   state_q, state_d;
    logic         long_q, long_d;
    logic         skip_q, skip_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [5:0]   index_q, index_d;
    logic [127:0] data_q, data_d;
    logic [6:0]   rxcrc_q, rxcrc_d;
    logic         trans_err_q, trans_err_d;
    logic         crc_err_q, crc_err_d;
    logic         frame_err_q, frame_err_d;

    logic         crc_clr;
    logic         crc_en;
    logic [6:0]   crc_calc;
    logic [7:0]   bit_n;
    logic [7:0]   last_bit;
    logic         in_index;
    logic         in_payload;
    logic         in_crc_field;
    logic         in_crc_cover;

`ifdef SDHC_RSP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_next;
    logic             timeout_q, timeout_d;
`endif

    sdhc_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (sd_cmd_in),
        .crc   (crc_calc)
    );

    // Field decode for the bit about to be sampled (bit_n = position 1..last)
    always_comb begin
        bit_n    = cnt_q + 8'd1;
        last_bit = long_q ? 8'(RSP_LONG_BITS) : 8'(RSP_SHORT_BITS);
        in_index = (bit_n >= 8'd3) && (bit_n <= 8'd8);
        if (long_q) begin
            in_payload   = (bit_n >= 8'd9)   && (bit_n <= 8'd135);
            in_crc_field = (bit_n >= 8'd129) && (bit_n <= 8'd135);
            in_crc_cover = (bit_n >= 8'd9)   && (bit_n <= 8'd128);
        end else begin
            in_payload   = (bit_n >= 8'd9)   && (bit_n <= 8'd40);
            in_crc_field = (bit_n >= 8'd41)  && (bit_n <= 8'd47);
            in_crc_cover = (bit_n <= 8'd40);
        end
    end

`ifdef SDHC_RSP_TIMEOUT_EN
    // Saturating strobe count while waiting for the start bit
    always_comb begin
        tmo_next = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
    end
`endif

    // Next-state and datapath updates; abort overrides everything else
    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        index_d     = index_q;
        data_d      = data_q;
        rxcrc_d     = rxcrc_q;
        trans_err_d = trans_err_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
`ifdef SDHC_RSP_TIMEOUT_EN
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
`endif

        if (abort) begin
            state_d = RSP_IDLE;
        end else begin
            case (state_q)
                RSP_IDLE, RSP_DONE: begin
                    state_d = RSP_IDLE;
                    if (arm) begin
                        state_d     = RSP_WAIT_START;
                        long_d      = long_rsp;
                        skip_d      = crc_skip;
                        cnt_d       = 8'd0;
                        index_d     = 6'd0;
                        data_d      = 128'd0;
                        rxcrc_d     = 7'd0;
                        trans_err_d = 1'b0;
                        crc_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                        crc_clr     = 1'b1;
`ifdef SDHC_RSP_TIMEOUT_EN
                        tmo_d       = '0;
                        timeout_d   = 1'b0;
`endif
                    end
                end

                RSP_WAIT_START: begin
                    if (sd_clk_rise) begin
                        if (!sd_cmd_in) begin
                            // Start bit is bit 1; it is only CRC-covered for short frames
                            state_d = RSP_RECV;
                            cnt_d   = 8'd1;
                            crc_en  = !long_q;
                        end else begin
`ifdef SDHC_RSP_TIMEOUT_EN
                            tmo_d = tmo_next;
                            if (32'(tmo_next) >= TIMEOUT_CLKS) begin
                                state_d   = RSP_DONE;
                                timeout_d = 1'b1;
                            end
`endif
                        end
                    end
                end

                RSP_RECV: begin
                    if (sd_clk_rise) begin
                        cnt_d  = bit_n;
                        crc_en = in_crc_cover;
                        if (bit_n == 8'd2) begin
                            trans_err_d = sd_cmd_in;
                        end
                        if (in_index) begin
                            index_d = {index_q[4:0], sd_cmd_in};
                        end
                        if (in_payload) begin
                            data_d = {data_q[126:0], sd_cmd_in};
                        end
                        if (in_crc_field) begin
                            rxcrc_d = {rxcrc_q[5:0], sd_cmd_in};
                        end
                        if (bit_n == last_bit) begin
                            state_d     = RSP_DONE;
                            frame_err_d = trans_err_q | ~sd_cmd_in;
                            crc_err_d   = skip_q ? 1'b0 : (crc_calc != rxcrc_q);
                            // Long payload lands in [127:1]; short keeps the argument only
                            data_d      = long_q ? {data_q[126:0], 1'b0} : (data_q & ARG_MASK);
                        end
                    end
                end

                default: begin
                    state_d = RSP_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RSP_IDLE;
            long_q      <= 1'b0;
            skip_q      <= 1'b0;
            cnt_q       <= 8'd0;
            index_q     <= 6'd0;
            data_q      <= 128'd0;
            rxcrc_q     <= 7'd0;
            trans_err_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            data_q      <= data_d;
            rxcrc_q     <= rxcrc_d;
            trans_err_q <= trans_err_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SDHC_RSP_TIMEOUT_EN
    // NCR timeout counter and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign busy          = (state_q == RSP_WAIT_START) || (state_q == RSP_RECV);
    assign rsp_valid     = (state_q == RSP_DONE);
    assign rsp_index     = index_q;
    assign rsp_data      = data_q;
    assign rsp_crc_err   = crc_err_q;
    assign rsp_frame_err = frame_err_q;

endmodule

// File: tb/tb_sdhc_rsp_rx.sv
// Testbench for sdhc_rsp_rx: directed response frames, expected results
// queued at issue time and compared by an independent monitor on rsp_valid.
// Build with +define+SDHC_RSP_TIMEOUT_EN to exercise the timeout path.
module tb_sdhc_rsp_rx;

    logic         clk;
    logic         rst_n;
    logic         sd_clk_rise;
    logic         sd_cmd_in;
    logic         arm;
    logic         long_rsp;
    logic         crc_skip;
    logic         abort;
    logic         busy;
    logic         rsp_valid;
    logic [5:0]   rsp_index;
    logic [127:0] rsp_data;
    logic         rsp_crc_err;
    logic         rsp_frame_err;
    logic         rsp_timeout;

    typedef struct {
        logic [5:0]   idx;
        logic [127:0] data;
        logic         crc_e;
        logic         frm_e;
        logic         tmo_e;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    sdhc_rsp_rx #(.DATAW(32), .TIMEOUT_CLKS(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sd_clk_rise   (sd_clk_rise),
        .sd_cmd_in     (sd_cmd_in),
        .arm           (arm),
        .long_rsp      (long_rsp),
        .crc_skip      (crc_skip),
        .abort         (abort),
        .busy          (busy),
        .rsp_valid     (rsp_valid),
        .rsp_index     (rsp_index),
        .rsp_data      (rsp_data),
        .rsp_crc_err   (rsp_crc_err),
        .rsp_frame_err (rsp_frame_err),
        .rsp_timeout   (rsp_timeout)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC7 over v[hi:lo], MSB first, initial zero
    function automatic logic [6:0] crc7_ref(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // 48-bit frame: start, transmission, index, argument, crc, end
    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg,
                                              input logic [6:0] crc, input logic trans,
                                              input logic endb);
        return {88'd0, 1'b0, trans, idx, arg, crc, endb};
    endfunction

    task automatic push_exp(input logic [5:0] idx, input logic [127:0] data, input logic crc_e,
                            input logic frm_e, input logic tmo_e, input int c);
        exp_t e;
        e.idx = idx; e.data = data; e.crc_e = crc_e; e.frm_e = frm_e; e.tmo_e = tmo_e; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every rsp_valid must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_index",     rsp_index,     e.idx);
                chk("rsp_data",      rsp_data,      e.data);
                chk("rsp_crc_err",   rsp_crc_err,   e.crc_e);
                chk("rsp_frame_err", rsp_frame_err, e.frm_e);
                chk("rsp_timeout",   rsp_timeout,   e.tmo_e);
                chk("valid_cycle",   cyc,           e.cyc);
                chk("busy_at_valid", busy,          1'b0);
            end
        end
    end

    // Driver tasks: all called at #1 after a rising clk edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b, input int gap);
        idle(gap);
        sd_clk_rise = 1'b1;
        sd_cmd_in   = b;
        @(posedge clk);
        #1;
        sd_clk_rise = 1'b0;
        sd_cmd_in   = 1'b1;
    endtask

    task automatic send_frame(input logic [135:0] f, input int len, input int gap, output int end_cyc);
        for (int i = len - 1; i >= 0; i--) strobe(f[i], gap);
        end_cyc = cyc;
    endtask

    task automatic arm_rsp(input logic lng, input logic skip);
        arm      = 1'b1;
        long_rsp = lng;
        crc_skip = skip;
        @(posedge clk);
        #1;
        arm      = 1'b0;
        long_rsp = 1'b0;
        crc_skip = 1'b0;
        chk("busy_after_arm",  busy,      1'b1);
        chk("index_zero_arm",  rsp_index, 6'd0);
        chk("data_zero_arm",   rsp_data,  128'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  busy,          1'b0);
        chk({tag, "_valid"}, rsp_valid,     1'b0);
        chk({tag, "_index"}, rsp_index,     6'd0);
        chk({tag, "_data"},  rsp_data,      128'd0);
        chk({tag, "_crc"},   rsp_crc_err,   1'b0);
        chk({tag, "_frame"}, rsp_frame_err, 1'b0);
        chk({tag, "_tmo"},   rsp_timeout,   1'b0);
    endtask

    // Safety net so the run always terminates
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [135:0] f;
        logic [127:0] cid;
        logic [6:0]   c7;
        int           end_c;

        rst_n = 1'b0; sd_clk_rise = 1'b0; sd_cmd_in = 1'b1;
        arm = 1'b0; long_rsp = 1'b0; crc_skip = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // R1 good frame, back-to-back strobes
        f = mk_short(6'd17, 32'h0000_0900, 7'd0, 1'b0, 1'b1);
        f[7:1] = crc7_ref(f, 47, 8);
        arm_rsp(1'b0, 1'b0);
        repeat (3) strobe(1'b1, 0);
        send_frame(f, 48, 0, end_c);
        push_exp(6'd17, 128'h0000_0900, 1'b0, 1'b0, 1'b0, end_c);
        idle(4);

        // Same R1 with one CRC bit flipped, strobe every third clk
        f = mk_short(6'd17, 32'h0000_0900, 7'd0, 1'b0, 1'b1);
        f[7:1] = crc7_ref(f, 47, 8);
        f[3] = ~f[3];
        arm_rsp(1'b0, 1'b0);
        send_frame(f, 48, 2, end_c);
        push_exp(6'd17, 128'h0000_0900, 1'b1, 1'b0, 1'b0, end_c);
        idle(4);

        // R3 with all-ones CRC field and crc_skip
        f = mk_short(6'h3F, 32'h80FF_8000, 7'h7F, 1'b0, 1'b1);
        arm_rsp(1'b0, 1'b1);
        strobe(1'b1, 1);
        send_frame(f, 48, 1, end_c);
        push_exp(6'h3F, 128'h80FF_8000, 1'b0, 1'b0, 1'b0, end_c);
        idle(4);

        // Transmission bit set, CRC otherwise consistent
        f = mk_short(6'd3, 32'h1234_5678, 7'd0, 1'b1, 1'b1);
        f[7:1] = crc7_ref(f, 47, 8);
        arm_rsp(1'b0, 1'b0);
        send_frame(f, 48, 0, end_c);
        push_exp(6'd3, 128'h1234_5678, 1'b0, 1'b1, 1'b0, end_c);
        idle(4);

        // End bit low
        f = mk_short(6'd8, 32'h0000_01AA, 7'd0, 1'b0, 1'b0);
        f[7:1] = crc7_ref(f, 47, 8);
        arm_rsp(1'b0, 1'b0);
        send_frame(f, 48, 0, end_c);
        push_exp(6'd8, 128'h0000_01AA, 1'b0, 1'b1, 1'b0, end_c);
        idle(4);

        // R2 long response carrying a CID with its correct CRC7
        cid = 128'h0353_4453_4430_3847_8012_3456_7801_2300;
        f = '0;
        f[127:0] = cid;
        c7 = crc7_ref(f, 127, 8);
        cid[7:1] = c7;
        f = {1'b0, 1'b0, 6'h3F, cid[127:1], 1'b1};
        arm_rsp(1'b1, 1'b0);
        strobe(1'b1, 0);
        send_frame(f, 136, 0, end_c);
        push_exp(6'h3F, {cid[127:1], 1'b0}, 1'b0, 1'b0, 1'b0, end_c);
        idle(4);
        chk("r2_top120", rsp_data[127:8], cid[127:8]);

        // Abort together with the 20th bit strobe; remainder must be ignored
        f = mk_short(6'd17, 32'h0000_0900, 7'd0, 1'b0, 1'b1);
        f[7:1] = crc7_ref(f, 47, 8);
        arm_rsp(1'b0, 1'b0);
        for (int i = 47; i > 28; i--) strobe(f[i], 0);
        sd_clk_rise = 1'b1;
        sd_cmd_in   = f[28];
        abort       = 1'b1;
        @(posedge clk);
        #1;
        abort       = 1'b0;
        sd_clk_rise = 1'b0;
        chk("busy_after_abort", busy, 1'b0);
        for (int i = 27; i >= 0; i--) strobe(f[i], 0);
        idle(4);
        chk("busy_idle_post_abort", busy, 1'b0);

        // Reset asserted after bit 30
        arm_rsp(1'b0, 1'b0);
        for (int i = 47; i > 17; i--) strobe(f[i], 0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midreset");
        idle(2);
        rst_n = 1'b1;
        for (int i = 17; i >= 0; i--) strobe(f[i], 0);
        idle(2);
        chk("busy_post_reset", busy, 1'b0);

        // Good frame after the reset
        f = mk_short(6'd55, 32'hDEAD_BEEF, 7'd0, 1'b0, 1'b1);
        f[7:1] = crc7_ref(f, 47, 8);
        arm_rsp(1'b0, 1'b0);
        send_frame(f, 48, 1, end_c);
        push_exp(6'd55, 128'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, end_c);
        idle(4);

`ifdef SDHC_RSP_TIMEOUT_EN
        // No start bit: completion one clk after the 64th strobe
        arm_rsp(1'b0, 1'b0);
        for (int i = 0; i < 63; i++) strobe(1'b1, i % 2);
        chk("busy_before_timeout", busy, 1'b1);
        strobe(1'b1, 0);
        end_c = cyc;
        push_exp(6'd0, 128'd0, 1'b0, 1'b0, 1'b1, end_c);
        idle(4);
`else
        // No start bit and no timeout counter: waits until aborted
        arm_rsp(1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) strobe(1'b1, 0);
        chk("busy_no_timeout", busy, 1'b1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("busy_after_abort2", busy, 1'b0);
        idle(4);
`endif

        chk("exp_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdhc_rsp_rx.md
# sdhc_rsp_rx

Receiver for SD-card command responses on the CMD line, paired with the SD host's command transmitter inside `sdhc`. When the host finishes sending a command, it arms this block. The block then:
- hunts for the card's start bit,
- deserialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response,
- checks CRC7 and framing,
- presents the result to the `sdhc` register file as a one-cycle completion pulse.

## Interface
- `DATAW`, 32 — width of the short-response argument field.
- `TIMEOUT_CLKS`, 64 — sample strobes allowed between arm and start bit (NCR limit); used only with `SDHC_RSP_TIMEOUT_EN`.
- `clk` input 1 — system clock, 100 MHz.
- `rst_n` input 1 — asynchronous, active-low reset.
- `sd_clk_rise` input 1 — one-`clk` strobe marking each SD clock rising edge; the CMD line is sampled only on these cycles.
- `sd_cmd_in` input 1 — CMD line, already registered by pad logic.
- `arm` input 1 — one-cycle request to start waiting for a response.
- `long_rsp` input 1 — captured at `arm`: 1 selects 136-bit R2, 0 selects 48-bit.
- `crc_skip` input 1 — captured at `arm`: 1 suppresses the CRC check (R3).
- `abort` input 1 — one-cycle cancel of any in-progress receive.
- `busy` output 1 — high from the cycle after `arm` until completion or abort.
- `rsp_valid` output 1 — one-cycle completion pulse.
- `rsp_index` output 6 — short: command index field; long: reserved field (6'h3F expected).
- `rsp_data` output 128 — short: argument in `[DATAW-1:0]`, upper bits 0; long: response bits `[127:1]` in `[127:1]`, `[0]` = 0.
- `rsp_crc_err` output 1 — CRC7 mismatch; valid with `rsp_valid`.
- `rsp_frame_err` output 1 — transmission bit ≠ 0 or end bit ≠ 1; valid with `rsp_valid`.
- `rsp_timeout` output 1 — no start bit within `TIMEOUT_CLKS`; valid with `rsp_valid`.

## Operation
States:
- **IDLE**: `busy` = 0. `arm` → WAIT_START; latch `long_rsp` and `crc_skip`; clear the bit counter, CRC and timeout counter.
- **WAIT_START**: on each strobe, `sd_cmd_in` = 0 → RECV, with the bit counter at 1 (start bit consumed); otherwise increment the timeout counter.
- **RECV**: shift one bit per strobe. The bit counter counts to 48 (short) or 136 (long).
  - Bit 2 is the transmission bit.
  - Short, bits 3–8: index. Bits 9–40: argument. Bits 41–47: CRC. Bit 48: end.
  - Long, bits 3–8: reserved field. Bits 9–135: payload `[127:1]`. Bit 136: end.
- **CRC coverage** (polynomial x^7+x^3+1, initial 0):
  - Short: bits 1–40.
  - Long: bits 9–128 only.
  - The computed CRC is compared with the received 7-bit CRC field.
- **DONE**: asserted for one cycle after the strobe that samples the end bit. `rsp_valid` = 1, error flags valid, then → IDLE.
- `rsp_index`/`rsp_data` hold their values until the next `arm`. They are zeroed at `arm`.
- `arm` while `busy` is ignored.
- `abort` in any state → IDLE next cycle, no `rsp_valid`. `abort` has priority over a simultaneous strobe or end bit.
- `rsp_crc_err` is forced 0 when `crc_skip` is latched. Frame checks always apply.

## Timing
- Reset values: `busy`, `rsp_valid`, `rsp_crc_err`, `rsp_frame_err`, `rsp_timeout` = 0; `rsp_index` = 0; `rsp_data` = 0; state = IDLE.
- Reset mid-receive returns to IDLE immediately; nothing is emitted.
- `busy` rises the `clk` after `arm`.
- `rsp_valid` rises exactly one `clk` after the end-bit strobe and lasts 1 `clk`. `busy` falls in that same cycle.
- Back-to-back strobes (`sd_clk_rise` = 1 every `clk`) are supported; one bit is accepted per strobe.
- The timeout counter saturates and does not wrap. It is compared with `>=`.

## Configuration
- `SDHC_RSP_TIMEOUT_EN` defined:
  - WAIT_START counts strobes.
  - The strobe that brings the count to `TIMEOUT_CLKS` without a start bit → DONE with `rsp_timeout` = 1 and other errors 0.
- Undefined:
  - No counter is built; WAIT_START waits indefinitely (exit via `abort`).
  - `rsp_timeout` is tied to 0.

## Structure
- Package `sdhc_pkg` holds:
  - the state enum `rsp_state_t`;
  - `RSP_SHORT_BITS` = 48 and `RSP_LONG_BITS` = 136;
  - `CRC7_POLY` = 7'h09.
- Sub-module `sdhc_crc7` provides serial CRC7 with ports `clk`, `rst_n`, `clr`, `en`, `din`, `crc[6:0]`. It is shared with the command transmitter.

## Test plan
- **R1 good frame**: arm short; drive index 6'd17, argument 32'h0000_0900, correct CRC7, end 1.
  - Required: `rsp_valid` 1 cycle after the end strobe; `rsp_index` = 17; `rsp_data[31:0]` = 32'h0000_0900; all errors 0.
- **CRC corruption**: same R1 frame with one CRC bit flipped → `rsp_crc_err` = 1, `rsp_frame_err` = 0.
- **R3 with `crc_skip`**: index 6'h3F, argument 32'h80FF_8000, CRC field 7'h7F → `rsp_crc_err` = 0, `rsp_data[31:0]` = 32'h80FF_8000.
- **R2 long**: 136-bit frame carrying CID 128'h0353_4453_4430_3847_8012_3456_7801_2300 with correct CRC → `rsp_data[127:8]` equals the CID's top 120 bits; `rsp_crc_err` = 0.
- **Timeout**: with `SDHC_RSP_TIMEOUT_EN`, hold `sd_cmd_in` = 1 → `rsp_valid` and `rsp_timeout` = 1 on the cycle after the 64th strobe. Without the macro, no `rsp_valid` occurs after 1000 strobes.
- **Abort and reset**: `abort` at bit 20 → `busy` = 0 next cycle, no `rsp_valid`. `rst_n` low at bit 30 → all outputs 0. A following good frame then decodes correctly.
